ga_alu_arbiter: RTL and testbench

Shares one ga_alu instance between NumReq requesters, for example the core GA issue port and the batch/DMA engine. Each requester uses a valid/ready request channel. All requesters share one response channel that carries a requester ID.
The block sequences the ALU's IDLE/COMPUTE/DONE protocol and holds operands stable for the whole operation. A timeout guard catches an ALU that never completes.

---
 rtl/ga_alu_arbiter.sv | 137 +++++++++++++
 tb/tb_ga_alu_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ga_alu_arbiter.sv
// ga_alu_arbiter: shares one ga_alu between NumReq valid/ready requesters with a tagged response channel.
// Define GA_ALU_ARB_PRIO_EN to give requester 0 strict priority over a round-robin of the others.
package ga_pkg;
  typedef struct packed {
    logic [15:0] e123;
    logic [15:0] e31;
    logic [15:0] e23;
    logic [15:0] e12;
    logic [15:0] e3;
    logic [15:0] e2;
    logic [15:0] e1;
    logic [15:0] scalar;
  } ga_multivector_t;
  typedef enum logic [1:0] {
    GA_FUNCT_ADD,
    GA_FUNCT_SUB,
    GA_FUNCT_MUL,
    GA_FUNCT_INV
  } ga_funct_e;
endpackage

module ga_alu_arbiter
  import ga_pkg::*;
#(
  parameter int NumReq        = 2,
  parameter int IdW           = (NumReq > 1) ? $clog2(NumReq) : 1,
  parameter int TimeoutCycles = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NumReq-1:0]     req_valid_i,
  output logic [NumReq-1:0]     req_ready_o,
  input  ga_multivector_t       req_operand_a_i [NumReq],
  input  ga_multivector_t       req_operand_b_i [NumReq],
  input  ga_funct_e             req_funct_i     [NumReq],
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [IdW-1:0]        rsp_id_o,
  output ga_multivector_t       rsp_result_o,
  output logic                  rsp_error_o,
  output logic                  alu_valid_o,
  input  logic                  alu_ready_i,
  output ga_multivector_t       alu_operand_a_o,
  output ga_multivector_t       alu_operand_b_o,
  output ga_funct_e             alu_operation_o,
  input  ga_multivector_t       alu_result_i,
  input  logic                  alu_error_i
);
`ifdef GA_ALU_ARB_PRIO_EN
  localparam bit Prio = 1'b1;
`else
  localparam bit Prio = 1'b0;
`endif
  localparam int CntW = $clog2(TimeoutCycles);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  state_e          state, state_n;
  logic [IdW-1:0]  rr_ptr, id_q, grant;
  logic [CntW-1:0] cnt;
  logic            found, timeout;
  int              idx;
  ga_multivector_t a_q, b_q, result_q;
  ga_funct_e       funct_q;
  logic            error_q;

  // Round-robin search from rr_ptr; in priority builds index 0 is handled up front and skipped here.
  always_comb begin
    found = 1'b0;
    grant = '0;
    idx   = 0;
    if (Prio && req_valid_i[0]) found = 1'b1;
    for (int i = 0; i < NumReq; i++) begin
      idx = (int'(rr_ptr) + i) % NumReq;
      if (!found && req_valid_i[idx] && !(Prio && idx == 0)) begin
        found = 1'b1;
        grant = IdW'(idx);
      end
    end
  end

  assign timeout = cnt == CntW'(TimeoutCycles - 1);

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  state_n = found ? S_ISSUE : S_IDLE;
      S_ISSUE: state_n = alu_ready_i ? S_WAIT : S_ISSUE;
      S_WAIT:  state_n = (alu_ready_i || timeout) ? S_RESP : S_WAIT;
      default: state_n = rsp_ready_i ? S_IDLE : S_RESP;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= S_IDLE;
      rr_ptr   <= '0;
      id_q     <= '0;
      cnt      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      funct_q  <= GA_FUNCT_ADD;
      result_q <= '0;
      error_q  <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        S_IDLE: if (found) begin
          a_q     <= req_operand_a_i[grant];
          b_q     <= req_operand_b_i[grant];
          funct_q <= req_funct_i[grant];
          id_q    <= grant;
        end
        S_ISSUE: if (alu_ready_i) cnt <= '0;
        S_WAIT: if (alu_ready_i) begin
          result_q <= alu_result_i;
          error_q  <= alu_error_i;
        end else if (timeout) begin
          result_q <= '0;
          error_q  <= 1'b1;
        end else cnt <= cnt + CntW'(1);
        default: if (rsp_ready_i) rr_ptr <= IdW'((int'(id_q) + 1) % NumReq);
      endcase
    end
  end

  // Gated by rst_ni so no accept is shown while reset is held.
  assign req_ready_o     = (rst_ni && state == S_IDLE && found) ? (NumReq'(1) << grant) : '0;
  assign alu_valid_o     = state == S_ISSUE;
  assign rsp_valid_o     = state == S_RESP;
  assign rsp_id_o        = id_q;
  assign rsp_result_o    = result_q;
  assign rsp_error_o     = error_q;
  assign alu_operand_a_o = a_q;
  assign alu_operand_b_o = b_q;
  assign alu_operation_o = funct_q;
endmodule

// File: tb/tb_ga_alu_arbiter.sv
// tb_ga_alu_arbiter: directed vectors and corner-case sequences for ga_alu_arbiter with a stub ALU.
module tb_ga_alu_arbiter;
  import ga_pkg::*;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic [1:0]      req_valid_i, req_ready_o;
  ga_multivector_t req_operand_a_i [2];
  ga_multivector_t req_operand_b_i [2];
  ga_funct_e       req_funct_i     [2];
  logic            rsp_valid_o, rsp_ready_i, rsp_error_o;
  logic [0:0]      rsp_id_o;
  ga_multivector_t rsp_result_o, alu_operand_a_o, alu_operand_b_o, alu_result_i;
  ga_funct_e       alu_operation_o;
  logic            alu_valid_o, alu_ready_i, alu_error_i;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  ga_alu_arbiter #(.NumReq(2), .IdW(1), .TimeoutCycles(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_operand_a_i(req_operand_a_i), .req_operand_b_i(req_operand_b_i), .req_funct_i(req_funct_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_id_o(rsp_id_o),
    .rsp_result_o(rsp_result_o), .rsp_error_o(rsp_error_o),
    .alu_valid_o(alu_valid_o), .alu_ready_i(alu_ready_i),
    .alu_operand_a_o(alu_operand_a_o), .alu_operand_b_o(alu_operand_b_o),
    .alu_operation_o(alu_operation_o), .alu_result_i(alu_result_i), .alu_error_i(alu_error_i)
  );

  // Stub ALU: IDLE(ready) -> COMPUTE(not ready) -> DONE(ready, result); hang freezes it in COMPUTE.
  logic [1:0]      ast;
  logic            hang;
  ga_multivector_t stub_res;
  logic            stub_err;

  function automatic ga_multivector_t fop(input ga_multivector_t a, input ga_multivector_t b, input logic sub);
    logic [127:0] x, y, r;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) r[16*i +: 16] = sub ? x[16*i +: 16] - y[16*i +: 16] : x[16*i +: 16] + y[16*i +: 16];
    return r;
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ast      <= 2'd0;
      stub_res <= '0;
      stub_err <= 1'b0;
    end else case (ast)
      2'd0: if (alu_valid_o) begin
        ast      <= 2'd1;
        stub_err <= alu_operation_o == GA_FUNCT_INV;
        stub_res <= alu_operation_o == GA_FUNCT_INV ? '0 :
                    fop(alu_operand_a_o, alu_operand_b_o, alu_operation_o == GA_FUNCT_SUB);
      end
      2'd1: if (!hang) ast <= 2'd2;
      default: ast <= 2'd0;
    endcase
  end

  assign alu_ready_i  = ast != 2'd1;
  assign alu_result_i = stub_res;
  assign alu_error_i  = stub_err;

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic issue(input int r, input ga_funct_e f, input ga_multivector_t a, input ga_multivector_t b);
    @(posedge clk_i); #1;
    req_funct_i[r]     = f;
    req_operand_a_i[r] = a;
    req_operand_b_i[r] = b;
    req_valid_i[r]     = 1'b1;
    @(negedge clk_i);
    chk($sformatf("accept_r%0d", r), req_ready_o, 2'b01 << r);
    @(posedge clk_i); #1;
    req_valid_i[r] = 1'b0;
  endtask

  task automatic wait_rsp(output int k);
    k = 0;
    do begin
      @(negedge clk_i);
      k++;
    end while (!rsp_valid_o && k < 50);
  endtask

  task automatic wait_accept(output logic [1:0] g);
    int k;
    k = 0;
    do begin
      @(negedge clk_i);
      k++;
    end while (req_ready_o == 2'b00 && k < 50);
    g = req_ready_o;
  endtask

  typedef struct {
    int          r;
    ga_funct_e   f;
    logic [15:0] as, ae1, bs, be1, xs, xe1;
    logic        xerr;
  } vec_t;

  vec_t            vecs [4];
  ga_multivector_t a, b;
  logic [1:0]      g;
  logic [1:0]      exp_g [4];
  int              k, seen;

  initial begin
    vecs[0] = '{0, GA_FUNCT_ADD, 16'd3,  16'd0,  16'd5, 16'd0, 16'd8,      16'd0,  1'b0};
    vecs[1] = '{1, GA_FUNCT_SUB, 16'd10, 16'd20, 16'd4, 16'd5, 16'd6,      16'd15, 1'b0};
    vecs[2] = '{0, GA_FUNCT_SUB, 16'd0,  16'd7,  16'd1, 16'd2, 16'hffff,   16'd5,  1'b0};
    vecs[3] = '{1, GA_FUNCT_INV, 16'd1,  16'd1,  16'd1, 16'd1, 16'd0,      16'd0,  1'b1};
`ifdef GA_ALU_ARB_PRIO_EN
    exp_g = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif
    hang        = 1'b0;
    rsp_ready_i = 1'b1;
    req_valid_i = 2'b11;
    for (int i = 0; i < 2; i++) begin
      req_operand_a_i[i] = '0;
      req_operand_b_i[i] = '0;
      req_funct_i[i]     = GA_FUNCT_ADD;
    end
    rst_ni = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("reset_ctl", {req_ready_o, rsp_valid_o, rsp_id_o, rsp_error_o, alu_valid_o}, '0);
    chk("reset_data", {rsp_result_o, alu_operand_a_o, alu_operation_o}, '0);
    req_valid_i = 2'b00;
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);

    for (int i = 0; i < 4; i++) begin
      a = '0; a.scalar = vecs[i].as; a.e1 = vecs[i].ae1;
      b = '0; b.scalar = vecs[i].bs; b.e1 = vecs[i].be1;
      issue(vecs[i].r, vecs[i].f, a, b);
      wait_rsp(k);
      chk($sformatf("v%0d_latency", i), k, 4);
      chk($sformatf("v%0d_id", i), rsp_id_o, vecs[i].r);
      chk($sformatf("v%0d_scalar", i), rsp_result_o.scalar, vecs[i].xs);
      chk($sformatf("v%0d_e1", i), rsp_result_o.e1, vecs[i].xe1);
      chk($sformatf("v%0d_err", i), rsp_error_o, vecs[i].xerr);
    end

    hang = 1'b1;
    a = '0; a.scalar = 16'd3;
    b = '0; b.scalar = 16'd5;
    issue(0, GA_FUNCT_ADD, a, b);
    wait_rsp(k);
    chk("to_latency", k, 18);
    chk("to_err", rsp_error_o, 1'b1);
    chk("to_result", rsp_result_o, '0);
    @(negedge clk_i);
    chk("to_idle", {rsp_valid_o, alu_valid_o}, 2'b00);
    hang = 1'b0;
    repeat (4) @(negedge clk_i);

    rsp_ready_i = 1'b0;
    a = '0; a.scalar = 16'd1;
    b = '0; b.scalar = 16'd2;
    issue(1, GA_FUNCT_ADD, a, b);
    a = '0; a.scalar = 16'd3;
    b = '0; b.scalar = 16'd5;
    req_operand_a_i[0] = a;
    req_operand_b_i[0] = b;
    req_funct_i[0]     = GA_FUNCT_ADD;
    req_valid_i[0]     = 1'b1;
    wait_rsp(k);
    chk("bp_latency", k, 4);
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("bp_hold%0d", i), {rsp_valid_o, rsp_id_o, rsp_error_o, rsp_result_o.scalar}, {1'b1, 1'b1, 1'b0, 16'd3});
      chk($sformatf("bp_noacc%0d", i), req_ready_o, 2'b00);
      @(negedge clk_i);
    end
    @(posedge clk_i); #1;
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    chk("bp_hs_noacc", req_ready_o, 2'b00);
    @(negedge clk_i);
    chk("bp_next_grant", req_ready_o, 2'b01);
    @(posedge clk_i); #1;
    req_valid_i[0] = 1'b0;
    wait_rsp(k);
    chk("bp_next_id", rsp_id_o, 1'b0);
    chk("bp_next_scalar", rsp_result_o.scalar, 16'd8);

    a = '0; a.scalar = 16'd9;
    b = '0; b.scalar = 16'd1;
    issue(0, GA_FUNCT_ADD, a, b);
    @(posedge clk_i); #1;
    rst_ni = 1'b0;
    #1;
    chk("midrst_ctl", {req_ready_o, rsp_valid_o, rsp_id_o, rsp_error_o, alu_valid_o}, '0);
    chk("midrst_data", {rsp_result_o, alu_operand_a_o}, '0);
    chk("midrst_op", {alu_operand_b_o, alu_operation_o}, '0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk_i);
      if (rsp_valid_o) seen++;
    end
    chk("midrst_no_rsp", seen, 0);

    @(posedge clk_i); #1;
    a = '0; a.e1 = 16'd10;
    b = '0; b.e1 = 16'd4;
    for (int i = 0; i < 2; i++) begin
      req_operand_a_i[i] = a;
      req_operand_b_i[i] = b;
      req_funct_i[i]     = GA_FUNCT_SUB;
    end
    req_valid_i = 2'b11;
    for (int i = 0; i < 4; i++) begin
      wait_accept(g);
      chk($sformatf("cont_grant%0d", i), g, exp_g[i]);
      wait_rsp(k);
      chk($sformatf("cont_lat%0d", i), k, 4);
      chk($sformatf("cont_id%0d", i), rsp_id_o, exp_g[i] == 2'b10);
      chk($sformatf("cont_e1_%0d", i), rsp_result_o.e1, 16'd6);
    end
    @(posedge clk_i); #1;
    req_valid_i = 2'b10;
    wait_accept(g);
    chk("drop0_grant", g, 2'b10);
    @(posedge clk_i); #1;
    req_valid_i = 2'b00;
    wait_rsp(k);
    chk("drop0_id", rsp_id_o, 1'b1);
    chk("drop0_e1", rsp_result_o.e1, 16'd6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
